// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - Round-robin sharing of one combinational ALU between two requesters
// S1 holds granted operands driving the ALU; S2 holds the result until its owner takes it.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              Flush,
  input  logic              ReqValid0,
  output logic              ReqReady0,
  input  logic [WIDTH-1:0]  ReqA0,
  input  logic [WIDTH-1:0]  ReqB0,
  input  logic [CTRL_W-1:0] ReqCtrl0,
  input  logic              ReqValid1,
  output logic              ReqReady1,
  input  logic [WIDTH-1:0]  ReqA1,
  input  logic [WIDTH-1:0]  ReqB1,
  input  logic [CTRL_W-1:0] ReqCtrl1,
  output logic              RespValid0,
  input  logic              RespReady0,
  output logic              RespValid1,
  input  logic              RespReady1,
  output logic [WIDTH-1:0]  RespData,
  output logic              RespZero,
  output logic [WIDTH-1:0]  AluBusA,
  output logic [WIDTH-1:0]  AluBusB,
  output logic [CTRL_W-1:0] AluCtrl,
  input  logic [WIDTH-1:0]  AluBusW,
  input  logic              AluZero
);

  logic              r_rr;
  logic              r_s1_valid;
  logic              r_s1_owner;
  logic [WIDTH-1:0]  r_s1_a;
  logic [WIDTH-1:0]  r_s1_b;
  logic [CTRL_W-1:0] r_s1_ctrl;
  logic              r_s2_valid;
  logic              r_s2_owner;
  logic [WIDTH-1:0]  r_s2_data;
  logic              r_s2_zero;

  logic w_s2_free;
  logic w_s1_free;
  logic w_can_grant;
  logic w_gnt0;
  logic w_gnt1;
  logic w_accept;

  assign RespValid0 = r_s2_valid & ~r_s2_owner;
  assign RespValid1 = r_s2_valid & r_s2_owner;
  assign RespData   = r_s2_data;
  assign RespZero   = r_s2_zero;
  assign AluBusA    = r_s1_a;
  assign AluBusB    = r_s1_b;
  assign AluCtrl    = r_s1_ctrl;

  assign w_s2_free   = ~r_s2_valid | (RespValid0 & RespReady0) | (RespValid1 & RespReady1);
  assign w_s1_free   = ~r_s1_valid | w_s2_free;
  // Reset_L gates the grant so ReqReady is low while reset is held.
  assign w_can_grant = Reset_L & w_s1_free & ~Flush;
  assign w_gnt0      = w_can_grant & ReqValid0 & (~ReqValid1 | ~r_rr);
  assign w_gnt1      = w_can_grant & ReqValid1 & (~ReqValid0 | r_rr);
  assign w_accept    = w_gnt0 | w_gnt1;
  assign ReqReady0   = w_gnt0;
  assign ReqReady1   = w_gnt1;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_rr       <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_owner <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ctrl  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_owner <= 1'b0;
      r_s2_data  <= '0;
      r_s2_zero  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr <= w_gnt0;
      end

      if (Flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_owner <= w_gnt1;
        r_s1_a     <= w_gnt1 ? ReqA1 : ReqA0;
        r_s1_b     <= w_gnt1 ? ReqB1 : ReqB0;
        r_s1_ctrl  <= w_gnt1 ? ReqCtrl1 : ReqCtrl0;
      end else if (w_s2_free) begin
        r_s1_valid <= 1'b0;
      end

      // Result registers keep their last value when S2 empties.
      if (Flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_owner <= r_s1_owner;
          r_s2_data  <= AluBusW;
          r_s2_zero  <= AluZero;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - Directed and randomized checks of alu_arbiter against a result scoreboard
module tb_alu_arbiter;

  logic        CLK;
  logic        Reset_L;
  logic        Flush;
  logic        ReqValid0, ReqReady0, ReqValid1, ReqReady1;
  logic [31:0] ReqA0, ReqB0, ReqA1, ReqB1;
  logic [3:0]  ReqCtrl0, ReqCtrl1;
  logic        RespValid0, RespReady0, RespValid1, RespReady1;
  logic [31:0] RespData;
  logic        RespZero;
  logic [31:0] AluBusA, AluBusB, AluBusW;
  logic [3:0]  AluCtrl;
  logic        AluZero;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  logic pref = 1'b0;
  logic a0, a1;
  logic [3:0] ops [5];

  alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Flush(Flush),
    .ReqValid0(ReqValid0), .ReqReady0(ReqReady0), .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqCtrl0(ReqCtrl0),
    .ReqValid1(ReqValid1), .ReqReady1(ReqReady1), .ReqA1(ReqA1), .ReqB1(ReqB1), .ReqCtrl1(ReqCtrl1),
    .RespValid0(RespValid0), .RespReady0(RespReady0),
    .RespValid1(RespValid1), .RespReady1(RespReady1),
    .RespData(RespData), .RespZero(RespZero),
    .AluBusA(AluBusA), .AluBusB(AluBusB), .AluCtrl(AluCtrl),
    .AluBusW(AluBusW), .AluZero(AluZero)
  );

  // Operation semantics of the ALU codes used here; also serves as the reference result.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  assign AluBusW = alu_fn(AluBusA, AluBusB, AluCtrl);
  assign AluZero = (AluBusW == 32'd0);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    Reset_L = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    Reset_L = 1'b1;
  endtask

  // Scoreboard: results owed in acceptance order, round-robin preference, flush/reset drop all.
  always @(negedge CLK) begin
    if (!Reset_L) begin
      q.delete();
      pref = 1'b0;
    end else begin
      chkb("one_ready", ReqReady0 & ReqReady1, 1'b0);
      chkb("ready_without_valid", (ReqReady0 & ~ReqValid0) | (ReqReady1 & ~ReqValid1), 1'b0);
      if (ReqValid0 & ReqValid1 & (ReqReady0 | ReqReady1))
        chkb("rr_grant", ReqReady1, pref);
      chkb("one_resp", RespValid0 & RespValid1, 1'b0);
      if (RespValid0 | RespValid1) begin
        if (q.size() == 0) begin
          chkb("unexpected_resp", RespValid0 | RespValid1, 1'b0);
        end else begin
          chkb("resp_owner", RespValid1, q[0].owner);
          chk("resp_data", RespData, q[0].data);
          chkb("resp_zero", RespZero, q[0].data == 32'd0);
          if (!Flush && ((RespValid0 & RespReady0) | (RespValid1 & RespReady1)))
            void'(q.pop_front());
        end
      end
      if (Flush) q.delete();
      if (ReqValid0 & ReqReady0) begin
        q.push_back({1'b0, alu_fn(ReqA0, ReqB0, ReqCtrl0)});
        pref = 1'b1;
      end
      if (ReqValid1 & ReqReady1) begin
        q.push_back({1'b1, alu_fn(ReqA1, ReqB1, ReqCtrl1)});
        pref = 1'b0;
      end
    end
  end

  initial begin
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    Reset_L = 1'b1; Flush = 1'b0;
    ReqValid0 = 1'b1; ReqA0 = 32'd1; ReqB0 = 32'd2; ReqCtrl0 = 4'b0010;
    ReqValid1 = 1'b1; ReqA1 = 32'd3; ReqB1 = 32'd4; ReqCtrl1 = 4'b0010;
    RespReady0 = 1'b1; RespReady1 = 1'b1;
    #1 Reset_L = 1'b0;
    #2;
    chkb("rst_ready0", ReqReady0, 1'b0);
    chkb("rst_ready1", ReqReady1, 1'b0);
    chkb("rst_resp0", RespValid0, 1'b0);
    chkb("rst_resp1", RespValid1, 1'b0);
    chk("rst_data", RespData, 32'd0);
    chkb("rst_zero", RespZero, 1'b0);
    chk("rst_busa", AluBusA, 32'd0);
    chk("rst_busb", AluBusB, 32'd0);
    chk("rst_ctrl", {28'd0, AluCtrl}, 32'd0);
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    do_reset();

    // Single ADD from requester 0
    ReqValid0 = 1'b1; ReqA0 = 32'd5; ReqB0 = 32'd7; ReqCtrl0 = 4'b0010;
    smp(); chkb("single_ready0", ReqReady0, 1'b1); tick();
    ReqValid0 = 1'b0;
    smp();
    chkb("single_early_resp", RespValid0, 1'b0);
    chk("single_busa", AluBusA, 32'd5);
    chk("single_busb", AluBusB, 32'd7);
    chk("single_ctrl", {28'd0, AluCtrl}, 32'd2);
    tick();
    smp();
    chkb("single_resp0", RespValid0, 1'b1);
    chk("single_data", RespData, 32'd12);
    chkb("single_zero", RespZero, 1'b0);
    chkb("single_resp1", RespValid1, 1'b0);
    tick();
    smp(); chkb("single_consumed", RespValid0, 1'b0); tick();

    // Contention from reset: grants alternate starting with requester 0
    do_reset();
    ReqValid0 = 1'b1; ReqA0 = 32'd9; ReqB0 = 32'd9; ReqCtrl0 = 4'b0110;
    ReqValid1 = 1'b1; ReqA1 = 32'hF0; ReqB1 = 32'h0F; ReqCtrl1 = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (i < 4) begin
        chkb("cont_ready0", ReqReady0, (i % 2) == 0);
        chkb("cont_ready1", ReqReady1, (i % 2) == 1);
      end
      if (i == 2) begin
        chkb("cont_resp0", RespValid0, 1'b1);
        chk("cont_data0", RespData, 32'd0);
        chkb("cont_zero0", RespZero, 1'b1);
      end
      if (i == 3) begin
        chkb("cont_resp1", RespValid1, 1'b1);
        chk("cont_data1", RespData, 32'hFF);
        chkb("cont_zero1", RespZero, 1'b0);
      end
      tick();
      if (i == 3) begin
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
      end
    end

    // Back-pressure on requester 1
    RespReady1 = 1'b0;
    ReqValid1 = 1'b1; ReqA1 = 32'hFFFF0000; ReqB1 = 32'h12345678; ReqCtrl1 = 4'b0000;
    smp(); chkb("bp_accept1", ReqReady1, 1'b1); tick();
    ReqA1 = 32'h10; ReqB1 = 32'h20; ReqCtrl1 = 4'b0010;
    smp(); chkb("bp_accept2", ReqReady1, 1'b1); tick();
    ReqA1 = 32'd1; ReqB1 = 32'd2; ReqCtrl1 = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      smp();
      chkb("bp_stall_ready", ReqReady1, 1'b0);
      chkb("bp_hold_valid", RespValid1, 1'b1);
      chk("bp_hold_data", RespData, 32'h12340000);
      tick();
    end
    RespReady1 = 1'b1;
    smp();
    chkb("bp_release_ready", ReqReady1, 1'b1);
    chk("bp_release_data", RespData, 32'h12340000);
    tick();
    ReqValid1 = 1'b0;
    smp(); chkb("bp_second_valid", RespValid1, 1'b1); chk("bp_second_data", RespData, 32'h30); tick();
    smp(); chk("bp_third_data", RespData, 32'd3); tick();
    smp(); chkb("bp_idle", RespValid1, 1'b0); tick();

    // Back-to-back streaming on requester 0
    RespReady0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        ReqValid0 = 1'b1; ReqA0 = i + 1; ReqB0 = i + 1; ReqCtrl0 = 4'b0010;
      end else begin
        ReqValid0 = 1'b0;
      end
      smp();
      if (i < 4) chkb("stream_ready", ReqReady0, 1'b1);
      if (i >= 2) begin
        chkb("stream_valid", RespValid0, 1'b1);
        chk("stream_data", RespData, 2 * (i - 1));
      end
      tick();
    end

    // Flush with both stages occupied
    RespReady0 = 1'b0;
    ReqValid0 = 1'b1; ReqA0 = 32'd3; ReqB0 = 32'd4; ReqCtrl0 = 4'b0010;
    smp(); chkb("fl_accept1", ReqReady0, 1'b1); tick();
    ReqA0 = 32'd10; ReqB0 = 32'd1; ReqCtrl0 = 4'b0110;
    smp(); chkb("fl_accept2", ReqReady0, 1'b1); tick();
    ReqA0 = 32'd6; ReqB0 = 32'd6; ReqCtrl0 = 4'b0010;
    ReqValid1 = 1'b1; ReqA1 = 32'd1; ReqB1 = 32'd1; ReqCtrl1 = 4'b0010;
    Flush = 1'b1; RespReady0 = 1'b1;
    smp();
    chkb("fl_ready0", ReqReady0, 1'b0);
    chkb("fl_ready1", ReqReady1, 1'b0);
    chkb("fl_resp_visible", RespValid0, 1'b1);
    chk("fl_resp_data", RespData, 32'd7);
    tick();
    Flush = 1'b0; ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      smp();
      chkb("fl_after_resp0", RespValid0, 1'b0);
      chkb("fl_after_resp1", RespValid1, 1'b0);
      tick();
    end

    // Asynchronous reset between edges with an operation in flight
    ReqValid0 = 1'b1; ReqA0 = 32'd2; ReqB0 = 32'd2; ReqCtrl0 = 4'b0010;
    smp(); chkb("ar_accept", ReqReady0, 1'b1); tick();
    ReqA0 = 32'd100; ReqB0 = 32'd100;
    ReqValid1 = 1'b1; ReqA1 = 32'd50; ReqB1 = 32'd5; ReqCtrl1 = 4'b0110;
    #2 Reset_L = 1'b0;
    #1;
    chkb("ar_ready0", ReqReady0, 1'b0);
    chkb("ar_ready1", ReqReady1, 1'b0);
    chkb("ar_resp0", RespValid0, 1'b0);
    chkb("ar_resp1", RespValid1, 1'b0);
    chk("ar_busa", AluBusA, 32'd0);
    chk("ar_busb", AluBusB, 32'd0);
    chk("ar_ctrl", {28'd0, AluCtrl}, 32'd0);
    tick();
    Reset_L = 1'b1;
    smp();
    chkb("ar_first_grant0", ReqReady0, 1'b1);
    chkb("ar_first_grant1", ReqReady1, 1'b0);
    tick();
    ReqValid0 = 1'b0;
    smp(); chkb("ar_second_grant1", ReqReady1, 1'b1); tick();
    ReqValid1 = 1'b0;
    smp(); chk("ar_new_data", RespData, 32'd200); tick();
    repeat (3) tick();

    // Randomized traffic
    a0 = 1'b0; a1 = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!ReqValid0 || a0) begin
        ReqValid0 = ($urandom_range(0, 2) != 0);
        ReqA0 = $urandom;
        ReqB0 = ($urandom_range(0, 3) == 0) ? ReqA0 : $urandom;
        ReqCtrl0 = ops[$urandom_range(0, 4)];
      end
      if (!ReqValid1 || a1) begin
        ReqValid1 = ($urandom_range(0, 2) != 0);
        ReqA1 = $urandom;
        ReqB1 = ($urandom_range(0, 3) == 0) ? ReqA1 : $urandom;
        ReqCtrl1 = ops[$urandom_range(0, 4)];
      end
      RespReady0 = ($urandom_range(0, 3) != 0);
      RespReady1 = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 39) == 0);
      smp();
      a0 = ReqValid0 & ReqReady0;
      a1 = ReqValid1 & ReqReady1;
      tick();
    end
    ReqValid0 = 1'b0; ReqValid1 = 1'b0; Flush = 1'b0;
    RespReady0 = 1'b1; RespReady1 = 1'b1;
    repeat (5) tick();
    smp();
    chk("drain_empty", q.size(), 32'd0);
    chkb("drain_resp0", RespValid0, 1'b0);
    chkb("drain_resp1", RespValid1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
